// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   FRAME_W         : width of one requester frame / UART_tx data word
//   TIMEOUT_DEFAULT : default bound on cycles spent waiting for tx_done
//   state_t         : arbiter FSM state encoding
package uart_ctrl_pkg;

   localparam int FRAME_W         = 16;
   localparam int TIMEOUT_DEFAULT = 32;

   typedef enum logic [2:0] {
      ST_FLUSH,   // after reset: let any in-flight UART frame drain
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_ACK
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req        : pending requests, one bit per requester
//   last_grant : index of the previous grant; search starts one above it
//   valid      : any request pending
//   index      : first set bit at or after last_grant+1, wrapping
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   logic [IDX_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit
   // (lowest offset from last_grant+1) is the one left standing.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = '0;
      for (int off = N_REQ; off >= 1; off--) begin
         cand = IDX_W'((int'(last_grant) + off) % N_REQ);
         if (req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
//   clk_9k6hz : single clock, shared with UART_tx
//   rst       : synchronous active-high reset
//   req       : per-requester frame pending
//   data_in   : requester i frame on [16i+15:16i]
//   ack       : one-cycle pulse on the completed requester's bit
//   err       : one-cycle pulse with ack when the frame timed out
//   busy      : state is not IDLE (combinational)
//   grant_id  : current / most recent grant
//   tx_data   : UART_tx data, frozen from SEND until the next grant
//   tx_en     : UART_tx enable, one cycle
//   tx_done   : UART_tx done pulse
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int TIMEOUT = TIMEOUT_DEFAULT,
   localparam int IDX_W   = $clog2(N_REQ)
) (
   input  logic                     clk_9k6hz,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [FRAME_W*N_REQ-1:0] data_in,
   output logic [N_REQ-1:0]         ack,
   output logic                     err,
   output logic                     busy,
   output logic [IDX_W-1:0]         grant_id,
   output logic [FRAME_W-1:0]       tx_data,
   output logic                     tx_en,
   input  logic                     tx_done
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t             state_q,      state_d;
   logic [TW-1:0]      timer_q,      timer_d;
   logic [IDX_W-1:0]   grant_id_q,   grant_id_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [FRAME_W-1:0] tx_data_q,    tx_data_d;
   logic               tx_en_q,      tx_en_d;
   logic [N_REQ-1:0]   ack_q,        ack_d;
   logic               err_q,        err_d;

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req        (req),
      .last_grant (last_grant_q),
      .valid      (pick_vld),
      .index      (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      tx_data_d    = tx_data_q;
      tx_en_d      = 1'b0;
      ack_d        = '0;
      err_d        = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            if (tx_done || timer_q == T_LAST) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (pick_vld) begin
               state_d    = ST_SEND;
               grant_id_d = pick_idx;
               tx_data_d  = data_in[pick_idx*FRAME_W +: FRAME_W];
               tx_en_d    = 1'b1;
            end
         end
         ST_SEND: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // ack/err are loaded on the way into ACK so they are high
            // during the ACK cycle itself. err carries err_pending; a
            // tx_done in the last timer cycle still counts as success.
            if (tx_done || timer_q == T_LAST) begin
               state_d = ST_ACK;
               ack_d   = N_REQ'(1) << grant_id_q;
               err_d   = ~tx_done;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_ACK: begin
            last_grant_d = grant_id_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clk_9k6hz) begin
      if (rst) begin
         state_q      <= ST_FLUSH;
         timer_q      <= '0;
         grant_id_q   <= '0;
         last_grant_q <= IDX_W'(N_REQ - 1);   // requester 0 wins first
         tx_data_q    <= '0;
         tx_en_q      <= 1'b0;
         ack_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         tx_data_q    <= tx_data_d;
         tx_en_q      <= tx_en_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_id_q;
   assign tx_data  = tx_data_q;
   assign tx_en    = tx_en_q;
   assign ack      = ack_q;
   assign err      = err_q;

endmodule
